starship_rom_arbiter: RTL and testbench
=======================================

# starship_rom_arbiter

Sequencer and two-port arbiter for the SoC mask/boot ROM macro (2048 × 32-bit, synchronous read, registered output, tri-stated by output enable). Sits between the ROM macro and two read requesters, port 0 = core/boot fetch path and port 1 = debug/loader path. Drives the macro's `me`, `oe` and `address` pins. Returns one 32-bit word per request over a valid/ready response channel, with an error flag for out-of-range addresses.

## Interface
- `BASE`, default 32'h0001_0000: byte base address of the ROM window.
- `DEPTH`, default 2048: ROM words; the window is `BASE` to `BASE + 4*DEPTH - 1`.
- `AW`, default 32: requester byte-address width.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, [1:0]: per-port request valid.
- `req_ready`, out, [1:0]: per-port request ready (grant).
- `req_addr0` / `req_addr1`, in, AW: byte address; bits [1:0] are ignored.
- `resp_valid`, out, 1: response valid.
- `resp_ready`, in, 1: response accepted.
- `resp_id`, out, 1: port that owns the response.
- `resp_data`, out, 32: read word; 0 on error.
- `resp_err`, out, 1: address was outside the window.
- `rom_me`, out, 1: to the macro's `me`.
- `rom_oe`, out, 1: to the macro's `oe`.
- `rom_address`, out, 11: word index to the macro.
- `rom_q`, in, 32: macro output; Z unless `rom_oe` is high.

## Operation
- FSM states: IDLE, READ, CAPT, RESP.
- IDLE:
  - `req_ready` is high for the granted port only, and only when that port's `req_valid` is high.
  - On handshake, latch the port id, the word index `(addr-BASE)>>2` and the range check.
  - In range: next state READ. Out of range: next state RESP with `resp_err`=1 and data 0, and the ROM is never enabled.
- READ: `rom_me`=1 and `rom_address`=latched index; next state CAPT.
- CAPT: `rom_oe`=1; `rom_q` is sampled into the response data register at the end of the cycle; next state RESP.
- RESP:
  - `resp_valid`=1; `resp_id`, `resp_data` and `resp_err` are held stable.
  - On `resp_ready`, go to IDLE; otherwise hold indefinitely.
- `rom_me` and `rom_oe` are 0 in every other state. `rom_address` holds its last value when not in READ.
- Range check:
  - Compute `addr - BASE` in AW+1 bits. A borrow means out of range; a quotient of `DEPTH` or more means out of range.
  - `rom_address` takes the low 11 bits of the quotient.
- Arbitration:
  - Takes effect only in IDLE and uses the `req_valid` values of the current cycle.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the tie is resolved as described under Configuration.
- Requesters may drop `req_valid` while not granted; no request is lost or duplicated.

## Timing
- Reset values: FSM in IDLE, `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `rom_me`=0, `rom_oe`=0, `rom_address`=0, round-robin pointer favouring port 0.
- Handshake at edge E0:
  - `rom_me` is high in the cycle E0–E1.
  - `rom_oe` is high in the cycle E1–E2.
  - `resp_valid` rises after E2, so the earliest `resp_valid` is 3 cycles after acceptance.
- Error path: `resp_valid` rises 1 cycle after acceptance.
- Throughput: at most one request per 4 cycles. `req_ready` is 0 in every state except IDLE; there is no overlap between requests.
- `req_ready` is combinational from `req_valid` and state; `resp_*` and `rom_*` are registered outputs.
- Asserting `reset` mid-transaction aborts the transaction: all outputs return to their reset values immediately and the in-flight response is discarded.

## Configuration
- `STARSHIP_ROM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer moves to the other port after each grant.
  - When both ports are valid, the port the pointer favours wins.
- Undefined: fixed priority, port 0 always wins ties, and no pointer register exists.

## Structure
- Shared package `starship_rom_pkg`: FSM state enum, `ROM_AW`=11, `ROM_DW`=32, default `BASE`/`DEPTH`.
- One sub-module, `starship_rom_rr_arb`: 2-way grant logic containing the pointer under the macro. The FSM and datapath stay in the top module.

## Test plan
- Port 0 reads `BASE+8` with the macro preloaded with word[2]=32'hDEAD_BEEF. Required: `rom_me` high exactly one cycle with `rom_address`=2; `resp_valid` 3 cycles after acceptance; `resp_data`=32'hDEAD_BEEF; `resp_id`=0; `resp_err`=0.
- Port 1 reads `BASE+4*2048`, then `BASE-4`. Required: each responds 1 cycle after acceptance with `resp_err`=1 and `resp_data`=0, and `rom_me` and `rom_oe` never assert.
- Both ports hold `req_valid` for 4 requests. Required with the macro: grants 0,1,0,1. Required without it: grants 0,0,0,0.
- `resp_ready` is held low for 10 cycles in RESP. Required: `resp_*` stable throughout, `req_ready`=0, and exactly one IDLE return after `resp_ready` rises.
- Assert `reset` in CAPT. Required: `rom_oe`, `resp_valid` and `req_ready` are 0 in the same cycle; after release, a fresh read of index 2047 (`BASE+8188`) returns the correct word.

Source files
------------

// File: rtl/starship_rom_pkg.sv
// starship_rom_pkg
// Shared definitions for the boot/mask ROM sequencer and arbiter:
//   - state_t  : sequencer FSM states (IDLE, READ, CAPT, RESP)
//   - ROM_AW   : word-index width of the ROM macro
//   - ROM_DW   : data width of the ROM macro
//   - DEF_BASE / DEF_DEPTH : default byte window base and word depth
package starship_rom_pkg;

    localparam int ROM_AW = 11;
    localparam int ROM_DW = 32;

    localparam logic [31:0] DEF_BASE  = 32'h0001_0000;
    localparam int unsigned DEF_DEPTH = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/starship_rom_rr_arb.sv
// starship_rom_rr_arb
// Two-way request arbiter for the ROM sequencer. Produces a one-hot (or
// zero) grant from the qualified request vector of the current cycle.
//
// Build option: STARSHIP_ROM_ARB_RR_EN
//   defined   : round-robin; a 1-bit pointer favours one port on ties and
//               moves to the other port after every grant.
//   undefined : fixed priority, port 0 wins ties, no pointer state.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset (pointer -> port 0)
//   req_valid  in   [1:0] requests, already qualified by the caller
//   grant      out  [1:0] one-hot grant, combinational
module starship_rom_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

`ifdef STARSHIP_ROM_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        // After a grant to port p the pointer favours the other port.
        if (|grant) begin
            ptr_d = grant[0];
        end
    end
`else
    // Fixed priority has no state; clock and reset are kept on the port list
    // so the instantiation is identical in both builds.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = 2'b01;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/starship_rom_arbiter.sv
// starship_rom_arbiter
// Sequencer and two-port arbiter for the 2048 x 32 synchronous boot ROM
// macro. Accepts one request at a time, drives me/oe/address to the macro,
// captures the registered macro output and returns it on a valid/ready
// response channel. Out-of-window addresses return resp_err=1, data 0,
// without touching the macro.
//
// Build option: STARSHIP_ROM_ARB_RR_EN selects round-robin tie breaking in
// starship_rom_rr_arb; otherwise port 0 has fixed priority.
//
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   req_valid/req_ready  per-port request handshake (ready is combinational)
//   req_addr0/req_addr1  byte addresses, bits [1:0] ignored
//   resp_valid/ready     response handshake; resp_id/data/err registered
//   rom_me, rom_oe       macro enable / output enable (registered)
//   rom_address          macro word index (registered, holds when idle)
//   rom_q                macro data, only meaningful while rom_oe is high
module starship_rom_arbiter
    import starship_rom_pkg::*;
#(
    parameter logic [31:0] BASE  = DEF_BASE,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int          AW    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [AW-1:0]     req_addr0,
    input  logic [AW-1:0]     req_addr1,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [ROM_DW-1:0] resp_data,
    output logic              resp_err,
    output logic              rom_me,
    output logic              rom_oe,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [ROM_DW-1:0] rom_q
);

    localparam logic [AW-1:0] BASE_A  = AW'(BASE);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t              state_q, state_d;
    logic                id_q, id_d;
    logic                err_q, err_d;
    logic [ROM_DW-1:0]   data_q, data_d;
    logic                resp_valid_q, resp_valid_d;
    logic                rom_me_q, rom_me_d;
    logic                rom_oe_q, rom_oe_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;

    // Arbitration only happens in IDLE; reset also forces ready low so no
    // handshake can be seen while the block is held in reset.
    logic [1:0] arb_valid;
    logic [1:0] grant;
    logic       handshake;
    logic       sel_port;

    assign arb_valid = req_valid & {2{(state_q == ST_IDLE) && !reset}};

    starship_rom_rr_arb u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_valid (arb_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign handshake = |grant;
    assign sel_port  = grant[1];

    // Range check: subtract in AW+1 bits so the top bit is the borrow.
    logic [AW-1:0] sel_addr;
    logic [AW:0]   diff;
    logic [AW-3:0] quot;
    logic          out_of_range;
    logic          unused_low_bits;

    assign sel_addr        = sel_port ? req_addr1 : req_addr0;
    assign diff            = {1'b0, sel_addr} - {1'b0, BASE_A};
    assign quot            = diff[AW-1:2];
    assign out_of_range    = diff[AW] || ({2'b00, quot} >= DEPTH_A);
    assign unused_low_bits = &{1'b0, diff[1:0]};

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        err_d      = err_q;
        data_d     = data_q;
        rom_addr_d = rom_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    id_d   = sel_port;
                    err_d  = out_of_range;
                    data_d = '0;
                    if (out_of_range) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_READ;
                        rom_addr_d = quot[ROM_AW-1:0];
                    end
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                // Macro output is driven during CAPT; capture at its end.
                data_d  = rom_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Macro controls and response valid are registered, so they are
        // decoded from the state being entered.
        rom_me_d     = (state_d == ST_READ);
        rom_oe_d     = (state_d == ST_CAPT);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            rom_me_q     <= 1'b0;
            rom_oe_q     <= 1'b0;
            rom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            err_q        <= err_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            rom_me_q     <= rom_me_d;
            rom_oe_q     <= rom_oe_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = id_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;
    assign rom_me      = rom_me_q;
    assign rom_oe      = rom_oe_q;
    assign rom_address = rom_addr_q;

endmodule

// File: tb/tb_starship_rom_arbiter.sv
// tb_starship_rom_arbiter
// Directed and randomized bench for starship_rom_arbiter with a behavioural
// ROM macro and a reference model built from the address window and the
// arbitration rules.
module tb_starship_rom_arbiter;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 2048;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0 = '0;
    logic [31:0] req_addr1 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        rom_me;
    logic        rom_oe;
    logic [10:0] rom_address;
    wire  [31:0] rom_q;

    int n_assert = 0;
    int n_fail   = 0;
    int rr_ptr   = 0;

    always #5 clock = ~clock;

    starship_rom_arbiter #(.BASE(BASE), .DEPTH(DEPTH), .AW(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .rom_me      (rom_me),
        .rom_oe      (rom_oe),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    // Behavioural ROM macro: synchronous read on me, registered output,
    // tri-stated unless oe is high.
    logic [31:0] rom_mem [DEPTH];
    logic [31:0] rom_out;
    always @(posedge clock) if (rom_me) rom_out <= rom_mem[rom_address];
    assign rom_q = rom_oe ? rom_out : 32'hzzzz_zzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: window check on plain integer addresses.
    function automatic void ref_read(input logic [31:0] addr, output logic err,
                                     output logic [31:0] data, output int idx);
        longint a, b;
        a = longint'(addr);
        b = longint'(BASE);
        if (a < b || a >= b + 4 * DEPTH) begin
            err = 1'b1; data = 32'h0; idx = 0;
        end else begin
            err = 1'b0; idx = int'((a - b) / 4); data = rom_mem[idx];
        end
    endfunction

    function automatic int ref_winner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef STARSHIP_ROM_ARB_RR_EN
        return rr_ptr;
`else
        return 0;
`endif
    endfunction

    // One transaction, entered and left at posedge+1.
    task automatic txn(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input int stall);
        int          port, idx, lat, me_cnt, oe_cnt;
        logic        exp_err;
        logic [31:0] exp_data, addr;
        req_valid = v; req_addr0 = a0; req_addr1 = a1;
        #1;
        port = ref_winner(v);
        chk("req_ready", {30'b0, req_ready}, (port == 1) ? 32'd2 : 32'd1);
        rr_ptr = 1 - port;
        addr = (port == 1) ? a1 : a0;
        ref_read(addr, exp_err, exp_data, idx);
        @(posedge clock); #1;
        req_valid = 2'b00;
        lat = 1; me_cnt = 0; oe_cnt = 0;
        while (!resp_valid && lat < 20) begin
            if (rom_me) begin
                me_cnt++;
                chk("rom_address", {21'b0, rom_address}, idx);
            end
            if (rom_oe) oe_cnt++;
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", lat, exp_err ? 1 : 3);
        chk("me_cycles", me_cnt, exp_err ? 0 : 1);
        chk("oe_cycles", oe_cnt, exp_err ? 0 : 1);
        chk("resp_id", {31'b0, resp_id}, port);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        chk("resp_data", resp_data, exp_data);
        $display("txn v=%b port=%0d addr=%h err=%0b data=%h lat=%0d stall=%0d",
                 v, port, addr, resp_err, resp_data, lat, stall);
        req_valid = 2'b11;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            chk("stall_valid", {31'b0, resp_valid}, 32'd1);
            chk("stall_data", resp_data, exp_data);
            chk("stall_id_err", {30'b0, resp_id, resp_err}, {30'b0, port[0], exp_err});
            chk("stall_ready", {30'b0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    endtask

    logic [31:0] w2047;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
        rom_mem[2] = 32'hDEAD_BEEF;
        w2047 = rom_mem[2047];

        // Reset values
        #12;
        chk("rst_outputs", {24'b0, req_ready, resp_valid, resp_id, resp_err, rom_me, rom_oe},
            32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_addr", {21'b0, rom_address}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic in-range read, then out-of-range above and below the window
        txn(2'b01, BASE + 8, 32'h0, 0);
        txn(2'b10, 32'h0, BASE + 4 * 2048, 0);
        txn(2'b10, 32'h0, BASE - 4, 0);

        // Both ports requesting continuously
        for (int i = 0; i < 4; i++) txn(2'b11, BASE + 4 * i, BASE + 4 * (100 + i), 0);

        // Long response back-pressure
        txn(2'b10, 32'h0, BASE + 4 * 77, 10);

        // Reset during CAPT
        req_valid = 2'b01; req_addr0 = BASE + 8;
        @(posedge clock); #1;
        req_valid = 2'b00;
        @(posedge clock); #1;
        chk("capt_oe", {31'b0, rom_oe}, 32'd1);
        req_valid = 2'b01;
        reset = 1'b1;
        #1;
        chk("rst_mid", {28'b0, rom_oe, resp_valid, req_ready}, 32'd0);
        chk("rst_mid_me", {31'b0, rom_me}, 32'd0);
        req_valid = 2'b00;
        @(posedge clock); #1;
        reset = 1'b0;
        rr_ptr = 0;
        @(posedge clock); #1;
        txn(2'b01, BASE + 8188, 32'h0, 0);
        chk("word2047", resp_data, w2047);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a [2];
            logic [1:0]  v;
            v = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 3))
                    0:       a[p] = BASE + 32'($urandom_range(0, 8191));
                    1:       a[p] = BASE + 8192 + 32'($urandom_range(0, 64));
                    2:       a[p] = BASE - 32'($urandom_range(1, 64));
                    default: a[p] = $urandom;
                endcase
            end
            txn(v, a[0], a[1], $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
